// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among functional units, registered
// broadcast of the winner's tag/data, and a saturating multi-request counter.
module cdb_arbiter #(
  parameter int N_REQ      = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*TAG_WIDTH-1:0]    req_tag,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              grant,
  input  logic                          cdb_stall,
  input  logic                          mask_wr,
  input  logic [N_REQ-1:0]              mask_in,
  output logic                          cdb_valid,
  output logic [TAG_WIDTH-1:0]          cdb_tag,
  output logic [DATA_WIDTH-1:0]         cdb_data,
  output logic [$clog2(N_REQ)-1:0]      cdb_src,
  output logic [15:0]                   conflict_cnt
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]      r_ptr;
  logic [N_REQ-1:0]      r_mask;
  logic                  r_valid;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [DATA_WIDTH-1:0] r_data;
  logic [PTR_W-1:0]      r_src;
  logic [15:0]           r_cnt;

  logic [N_REQ-1:0]      w_eligible;
  logic [N_REQ-1:0]      w_grant;
  logic                  w_found;
  logic [PTR_W-1:0]      w_win;
  logic                  w_multi;

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return PTR_W'(sum);
  endfunction

  // Reset gates eligibility so grant is forced low while rst is held.
  assign w_eligible = req & r_mask & {N_REQ{~cdb_stall}} & {N_REQ{~rst}};

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign w_multi = |(w_eligible & (w_eligible - N_REQ'(1)));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_grant = '0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && w_eligible[wrap_idx(r_ptr, k)]) begin
        w_found                    = 1'b1;
        w_win                      = wrap_idx(r_ptr, k);
        w_grant[wrap_idx(r_ptr, k)] = 1'b1;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_mask  <= '1;
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
      r_src   <= '0;
      r_cnt   <= '0;
    end else begin
      if (mask_wr) r_mask <= mask_in;
      r_valid <= w_found;
      if (w_found) begin
        r_tag  <= req_tag[int'(w_win)*TAG_WIDTH +: TAG_WIDTH];
        r_data <= req_data[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
        r_src  <= w_win;
        r_ptr  <= wrap_idx(w_win, 1);
      end
      if (w_multi && (r_cnt != 16'hFFFF)) r_cnt <= r_cnt + 16'd1;
    end
  end

  assign grant        = w_grant;
  assign cdb_valid    = r_valid;
  assign cdb_tag      = r_tag;
  assign cdb_data     = r_data;
  assign cdb_src      = r_src;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter with the default 4-unit configuration.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_tag;
  logic [127:0] req_data;
  logic [3:0]  grant;
  logic        cdb_stall;
  logic        mask_wr;
  logic [3:0]  mask_in;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;
  logic [15:0] conflict_cnt;

  int n_cmp = 0;
  int n_err = 0;

  cdb_arbiter #(.N_REQ(4), .TAG_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_tag      (req_tag),
    .req_data     (req_data),
    .grant        (grant),
    .cdb_stall    (cdb_stall),
    .mask_wr      (mask_wr),
    .mask_in      (mask_in),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .cdb_src      (cdb_src),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int i, input logic [3:0] t, input logic [31:0] d);
    req_tag[i*4 +: 4]   = t;
    req_data[i*32 +: 32] = d;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_tag = '0; req_data = '0;
    cdb_stall = 1'b0; mask_wr = 1'b0; mask_in = '0;
    tick(); tick();

    // Reset state, and grant held low under reset despite requests
    req = 4'hF;
    #1 check("rst_grant", grant, 0);
    check("rst_valid", cdb_valid, 0);
    check("rst_tag", cdb_tag, 0);
    check("rst_data", cdb_data, 0);
    check("rst_src", cdb_src, 0);
    check("rst_cnt", conflict_cnt, 0);
    req = '0;
    rst = 1'b0;

    // All four request, each drops on grant: 0,1,2,3 in turn, three conflict cycles
    for (int i = 0; i < 4; i++) set_unit(i, 4'(i + 1), 32'h100 + i);
    req = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1 check("rr_grant", grant, 32'(1 << i));
      tick();
      req[i] = 1'b0;
      check("rr_valid", cdb_valid, 1);
      check("rr_src", cdb_src, i);
      check("rr_tag", cdb_tag, i + 1);
      check("rr_data", cdb_data, 32'h100 + i);
    end
    #1 check("rr_cnt", conflict_cnt, 3);

    // Stall for two cycles: nothing granted or counted, pointer stays at 0
    cdb_stall = 1'b1;
    req = 4'b0011;
    repeat (2) begin
      #1 check("stall_grant", grant, 0);
      tick();
      check("stall_valid", cdb_valid, 0);
    end
    check("stall_cnt", conflict_cnt, 3);
    cdb_stall = 1'b0;
    #1 check("unstall_grant", grant, 4'b0001);
    tick();
    req = 4'b0010;
    check("unstall_src", cdb_src, 0);
    #1 check("unstall_grant2", grant, 4'b0010);
    tick();
    req = '0;
    check("unstall_src2", cdb_src, 1);
    check("unstall_cnt", conflict_cnt, 4);

    // Single request from unit 2, then outputs hold once valid drops
    set_unit(2, 4'd5, 32'h10);
    req = 4'b0100;
    #1 check("single_grant", grant, 4'b0100);
    tick();
    req = '0;
    check("single_valid", cdb_valid, 1);
    check("single_tag", cdb_tag, 5);
    check("single_data", cdb_data, 32'h10);
    check("single_src", cdb_src, 2);
    tick();
    check("idle_valid", cdb_valid, 0);
    check("idle_tag_hold", cdb_tag, 5);
    check("idle_data_hold", cdb_data, 32'h10);
    check("idle_src_hold", cdb_src, 2);

    // Pointer at 3 with units 3 and 0 requesting: 3 first, then wrap to 0
    req = 4'b1001;
    #1 check("wrap_grant3", grant, 4'b1000);
    tick();
    req = 4'b0001;
    check("wrap_src3", cdb_src, 3);
    #1 check("wrap_grant0", grant, 4'b0001);
    tick();
    req = '0;
    check("wrap_src0", cdb_src, 0);
    check("wrap_cnt", conflict_cnt, 5);

    // Mask write cycle still uses the old mask; unit 0 is blocked afterwards
    mask_wr = 1'b1;
    mask_in = 4'b1110;
    req = 4'b0001;
    #1 check("maskwr_grant", grant, 4'b0001);
    tick();
    mask_wr = 1'b0;
    check("maskwr_valid", cdb_valid, 1);
    check("maskwr_src", cdb_src, 0);
    #1 check("masked_grant_a", grant, 0);
    tick();
    check("masked_valid", cdb_valid, 0);
    #1 check("masked_grant_b", grant, 0);
    tick();
    req = '0;

    // All-zero mask: no grants, and masked requests are not conflicts
    mask_wr = 1'b1;
    mask_in = 4'b0000;
    tick();
    mask_wr = 1'b0;
    req = 4'hF;
    #1 check("zmask_grant", grant, 0);
    tick();
    check("zmask_valid", cdb_valid, 0);
    check("zmask_cnt", conflict_cnt, 5);
    req = '0;
    mask_wr = 1'b1;
    mask_in = 4'hF;
    tick();
    mask_wr = 1'b0;

    // Long conflicting run brings the counter to FFFE, then it saturates
    req = 4'b0011;
    repeat (65529) tick();
    check("sat_pre", conflict_cnt, 16'hFFFE);
    repeat (3) tick();
    check("sat_hold", conflict_cnt, 16'hFFFF);
    check("sat_valid", cdb_valid, 1);

    // Reset in the middle of broadcasting drops the pending output
    rst = 1'b1;
    #1 check("midrst_grant", grant, 0);
    tick();
    check("midrst_valid", cdb_valid, 0);
    check("midrst_cnt", conflict_cnt, 0);
    check("midrst_src", cdb_src, 0);
    rst = 1'b0;
    req = '0;
    tick();
    check("postrst_valid", cdb_valid, 0);
    req = 4'b0011;
    #1 check("postrst_grant", grant, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
